// File: rtl/w5300_access_seq.sv
// ---------------------------------------------------------------------------
// w5300_access_seq
//
// Upstream sequencer for w5300_interface. The interface starts a new access
// on every Idle cycle (ctrl_op_state = 1) and then holds op_state low for
// SETUP_TICKS+1 cycles. This block follows that slot rhythm, presents one
// access per slot on ctrl_addr/ctrl_wr_data, and fills slots without burst
// work with a dummy "park" read of PARK_ADDR.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ctrl_addr         [10] = operation (1 = write, 0 = read), [9:0] = address
//   ctrl_wr_data      write word for the current access
//   ctrl_rd_data      read word from the interface, captured at slot end
//   ctrl_op_state     1 = interface Idle (slot start)
//   req_*             burst request (write/read, start addr, len-1, fixed)
//   wd_valid/ready    write-word stream; wd_ready is high in the cycle the
//                     word is consumed
//   rd_valid/rd_data  read-word stream, one-cycle pulse per word
//   done              one-cycle pulse when the last burst word completes
//   sync_err          sticky slot-framing error
//   dbg_state         current FSM state (INIT/PARK/XFER)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready and wd_ready never depend combinationally on their
// own valid except wd_ready, which is only asserted while wd_valid is high.
// ---------------------------------------------------------------------------
module w5300_access_seq #(
  parameter int         SETUP_TICKS = 5,
  parameter logic [9:0] PARK_ADDR   = 10'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] ctrl_addr,
  output logic [15:0] ctrl_wr_data,
  input  logic [15:0] ctrl_rd_data,
  input  logic        ctrl_op_state,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [9:0]  req_addr,
  input  logic [7:0]  req_len,
  input  logic        req_fixed,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [15:0] wd_data,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        done,
  output logic        sync_err,
  output logic [1:0]  dbg_state
);

  localparam int            CW      = (SETUP_TICKS < 1) ? 1 : $clog2(SETUP_TICKS + 1);
  localparam logic [CW-1:0] LO_LAST = CW'(SETUP_TICKS);
  localparam logic          OP_WR   = 1'b1;
  localparam logic          OP_RD   = 1'b0;

  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_PARK = 2'd1, ST_XFER = 2'd2} state_t;

  state_t        r_state, w_state_nx;

  // slot tracking
  logic          r_synced, r_after_bnd, r_sync_err;
  logic [CW-1:0] r_lo_cnt;
  // pending (accepted, not yet started) request
  logic          r_pend, r_pq_write, r_pq_fixed;
  logic [9:0]    r_pq_addr;
  logic [7:0]    r_pq_len;
  // active burst: next word to load and words still to load
  logic          r_b_write, r_b_fixed;
  logic [9:0]    r_b_addr;
  logic [8:0]    r_b_left;
  // access currently in flight on the interface
  logic          r_cur_word, r_cur_read, r_cur_last;
  // output registers
  logic [10:0]   r_ctrl_addr;
  logic [15:0]   r_ctrl_wr_data, r_rd_data;
  logic          r_rd_valid, r_done;

  logic          w_boundary, w_err_hi;
  logic          w_start, w_advance, w_go, w_take;
  logic          w_src_write, w_src_fixed;
  logic [9:0]    w_src_addr, w_next_addr;
  logic [8:0]    w_src_left;
  logic          w_req_ready;

  // Boundary = last low cycle of a correctly framed access.
  assign w_boundary  = r_synced & ~ctrl_op_state & ~r_after_bnd & (r_lo_cnt == LO_LAST);
  // Idle seen anywhere except right after our boundary: the access ended early.
  assign w_err_hi    = r_synced & ctrl_op_state & ~r_after_bnd;
  assign w_req_ready = ~r_pend & (r_state != ST_XFER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_advance  = 1'b0;
    case (r_state)
      ST_INIT: if (ctrl_op_state) w_state_nx = ST_PARK;
      ST_PARK: if (w_boundary && r_pend) begin
        w_start    = 1'b1;
        w_state_nx = ST_XFER;
      end
      ST_XFER: if (w_boundary) begin
        // XFER lasts until the boundary of the last loaded word.
        if (r_b_left != 9'd0) w_advance = 1'b1;
        else if (r_pend)      w_start   = 1'b1;
        else                  w_state_nx = ST_PARK;
      end
      default: w_state_nx = ST_INIT;
    endcase

    w_src_write = w_start ? r_pq_write : r_b_write;
    w_src_fixed = w_start ? r_pq_fixed : r_b_fixed;
    w_src_addr  = w_start ? r_pq_addr  : r_b_addr;
    w_src_left  = w_start ? ({1'b0, r_pq_len} + 9'd1) : r_b_left;
    w_next_addr = w_src_addr + (w_src_fixed ? 10'd0 : 10'd2);
    w_go        = w_start | w_advance;
    // A write word without data is skipped for this slot (park read instead).
    w_take      = w_go & (~w_src_write | wd_valid);
  end

  // Slot counter and framing check. Any Idle cycle resynchronises the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_synced    <= 1'b0;
      r_after_bnd <= 1'b0;
      r_lo_cnt    <= '0;
      r_sync_err  <= 1'b0;
    end else if (ctrl_op_state) begin
      r_synced    <= 1'b1;
      r_after_bnd <= 1'b0;
      r_lo_cnt    <= '0;
      if (w_err_hi) r_sync_err <= 1'b1;
    end else if (r_synced) begin
      if (r_after_bnd) begin
        // Access ran long: drop sync and wait for the next Idle.
        r_sync_err  <= 1'b1;
        r_synced    <= 1'b0;
        r_after_bnd <= 1'b0;
      end else if (w_boundary) begin
        r_lo_cnt    <= '0;
        r_after_bnd <= 1'b1;
      end else begin
        r_lo_cnt    <= r_lo_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= 1'b0;
      r_pq_write <= 1'b0;
      r_pq_fixed <= 1'b0;
      r_pq_addr  <= '0;
      r_pq_len   <= '0;
    end else if (w_start) begin
      r_pend     <= 1'b0;
    end else if (req_valid && w_req_ready) begin
      r_pend     <= 1'b1;
      r_pq_write <= req_write;
      r_pq_fixed <= req_fixed;
      r_pq_addr  <= req_addr;
      r_pq_len   <= req_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_write <= 1'b0;
      r_b_fixed <= 1'b0;
      r_b_addr  <= '0;
      r_b_left  <= '0;
    end else if (w_go) begin
      r_b_write <= w_src_write;
      r_b_fixed <= w_src_fixed;
      r_b_addr  <= w_take ? w_next_addr : w_src_addr;
      r_b_left  <= w_take ? (w_src_left - 9'd1) : w_src_left;
    end
  end

  // Outputs change only at the edge ending a boundary cycle, so they are
  // stable from the interface's Idle cycle through its last low cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl_addr    <= {OP_RD, PARK_ADDR};
      r_ctrl_wr_data <= '0;
      r_rd_valid     <= 1'b0;
      r_rd_data      <= '0;
      r_done         <= 1'b0;
      r_cur_word     <= 1'b0;
      r_cur_read     <= 1'b0;
      r_cur_last     <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      if (w_boundary) begin
        if (r_cur_word && r_cur_read) begin
          r_rd_valid <= 1'b1;
          r_rd_data  <= ctrl_rd_data;
        end
        if (r_cur_word && r_cur_last) r_done <= 1'b1;
        if (w_take) begin
          r_ctrl_addr    <= {(w_src_write ? OP_WR : OP_RD), w_src_addr};
          r_ctrl_wr_data <= w_src_write ? wd_data : 16'h0000;
          r_cur_word     <= 1'b1;
          r_cur_read     <= ~w_src_write;
          r_cur_last     <= (w_src_left == 9'd1);
        end else begin
          r_ctrl_addr    <= {OP_RD, PARK_ADDR};
          r_ctrl_wr_data <= '0;
          r_cur_word     <= 1'b0;
          r_cur_read     <= 1'b0;
          r_cur_last     <= 1'b0;
        end
      end
    end
  end

  assign ctrl_addr    = r_ctrl_addr;
  assign ctrl_wr_data = r_ctrl_wr_data;
  assign req_ready    = w_req_ready;
  assign wd_ready     = w_take & w_src_write;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_data;
  assign done         = r_done;
  assign sync_err     = r_sync_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_w5300_access_seq.sv
module tb_w5300_access_seq;

  localparam int         INIT_LO = 5200;
  localparam logic       OP_WR   = 1'b1;
  localparam logic       OP_RD   = 1'b0;
  localparam logic [9:0] PARK    = 10'h000;

  logic        clk, rst_n;
  logic [10:0] ctrl_addr;
  logic [15:0] ctrl_wr_data, ctrl_rd_data;
  logic        ctrl_op_state;
  logic        req_valid, req_ready, req_write, req_fixed;
  logic [9:0]  req_addr;
  logic [7:0]  req_len;
  logic        wd_valid, wd_ready;
  logic [15:0] wd_data;
  logic        rd_valid, done, sync_err;
  logic [15:0] rd_data;
  logic [1:0]  dbg_state;

  w5300_access_seq #(.SETUP_TICKS(5), .PARK_ADDR(10'h000)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_addr(ctrl_addr), .ctrl_wr_data(ctrl_wr_data),
    .ctrl_rd_data(ctrl_rd_data), .ctrl_op_state(ctrl_op_state),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_fixed(req_fixed),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done),
    .sync_err(sync_err), .dbg_state(dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [26:0] exp_acc_q[$];   // {ctrl_addr, write data (0 for reads)}
  logic [15:0] exp_rd_q[$];
  logic        exp_done_q[$];  // rd_valid expected alongside done
  logic [19:0] req_q[$];       // {write, fixed, addr[9:0], len[7:0]}
  logic [15:0] wd_q[$];

  // interface model / monitor state
  int          cyc = 0;
  bit          m_running = 0;
  int          m_init = INIT_LO;
  int          m_phase = 0;
  int          m_lows = 6;
  logic [10:0] m_addr = '0;
  logic [15:0] m_data = '0;
  int          m_bnd_cnt = 0;
  int          stab_err = 0;
  int          park_cnt = 0;
  int          short_req_cnt = 0;
  int          short_done_cnt = 0;
  int          done_cnt = 0, rd_cnt = 0, wdr_cnt = 0, acc_cnt = 0;
  bit          req_acc = 0;
  bit          rd_active = 0;
  int          last_rd_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] f_rd(input logic [10:0] a);
    return {a[9:0], a[5:0]} ^ 16'h3C5A;
  endfunction

  // Interface model, request/write-word driver and output monitor.
  initial begin
    logic [19:0] r;
    logic [26:0] e;
    ctrl_op_state = 1'b0; ctrl_rd_data = 16'hDEAD;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0; req_fixed = 1'b0;
    wd_valid = 1'b0; wd_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_running = 0; m_init = INIT_LO; m_phase = 0; m_lows = 6;
        ctrl_op_state = 1'b0; ctrl_rd_data = 16'hDEAD;
        req_valid = 1'b0; req_acc = 0; wd_valid = 1'b0;
      end else begin
        // drive inputs for this cycle
        if (req_acc) begin req_valid = 1'b0; req_acc = 0; acc_cnt++; end
        if (!req_valid && req_q.size() > 0) begin
          r = req_q.pop_front();
          {req_write, req_fixed, req_addr, req_len} = r;
          req_valid = 1'b1;
        end
        wd_valid = (wd_q.size() > 0);
        wd_data  = wd_valid ? wd_q[0] : 16'h0000;
        if (!m_running) begin
          if (m_init > 0) m_init--;
          else begin m_running = 1; m_phase = 0; m_lows = 6; end
        end else if (m_phase == m_lows) begin
          m_phase = 0;
          m_lows  = 6;
          if (short_done_cnt != short_req_cnt) begin m_lows = 5; short_done_cnt++; end
        end else begin
          m_phase++;
        end
        ctrl_op_state = m_running && (m_phase == 0);
        ctrl_rd_data  = (m_running && m_phase > 0 && m_phase >= m_lows - 2) ? f_rd(m_addr) : 16'hDEAD;

        #1;
        // access framing and content
        if (m_running && m_phase == 0) begin
          m_addr = ctrl_addr;
          m_data = ctrl_wr_data;
          if (ctrl_addr == {OP_RD, PARK}) park_cnt++;
          else if (exp_acc_q.size() == 0)
            check_eq("acc_unexp", {5'b0, ctrl_addr, ctrl_wr_data}, {5'b0, OP_RD, PARK, 16'h0});
          else begin
            e = exp_acc_q.pop_front();
            check_eq("acc", {5'b0, ctrl_addr, (ctrl_addr[10] == OP_WR) ? ctrl_wr_data : 16'h0}, {5'b0, e});
          end
        end else if (m_running) begin
          if (ctrl_addr !== m_addr || ctrl_wr_data !== m_data) stab_err++;
          if (m_phase == m_lows) m_bnd_cnt++;
        end
        // request handshake completes at the coming edge
        if (req_valid && req_ready) req_acc = 1;
        // write-word consumption
        if (wd_ready) begin
          wdr_cnt++;
          check_eq("wdr_at_bnd", (m_running && m_phase == m_lows), 1);
          if (wd_valid && wd_q.size() > 0) void'(wd_q.pop_front());
          else check_eq("wdr_novalid", wd_ready, 0);
        end
        // read words
        if (rd_valid) begin
          rd_cnt++;
          check_eq("rdv_idle", ctrl_op_state, 1);
          if (exp_rd_q.size() > 0) check_eq("rd_data", rd_data, exp_rd_q.pop_front());
          else check_eq("rd_unexp", rd_valid, 0);
          if (rd_active) check_eq("rd_gap", cyc - last_rd_cyc, 7);
          rd_active   = 1;
          last_rd_cyc = cyc;
        end
        // burst completion
        if (done) begin
          done_cnt++;
          rd_active = 0;
          check_eq("done_idle", ctrl_op_state, 1);
          if (exp_done_q.size() > 0) check_eq("done_rdv", rd_valid, exp_done_q.pop_front());
          else check_eq("done_unexp", done, 0);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic push_wd(input logic [15:0] seed, input int n);
    for (int i = 0; i < n; i++) wd_q.push_back(seed + 16'(i) * 16'h0101);
  endtask

  // Queue a request and its expected accesses, read words and done pulse,
  // then wait until the DUT accepts it.
  task automatic send_req(input bit wr, input logic [9:0] a, input logic [7:0] len,
                          input bit fixed, input logic [15:0] seed);
    logic [9:0] ad;
    int         k, target;
    ad = a;
    for (int i = 0; i <= int'(len); i++) begin
      if (wr) exp_acc_q.push_back({OP_WR, ad, seed + 16'(i) * 16'h0101});
      else begin
        if (ad != PARK) exp_acc_q.push_back({OP_RD, ad, 16'h0});
        exp_rd_q.push_back(f_rd({OP_RD, ad}));
      end
      if (!fixed) ad = ad + 10'd2;
    end
    exp_done_q.push_back(!wr);
    target = acc_cnt + 1;
    req_q.push_back({wr, fixed, a, len});
    k = 0;
    while (acc_cnt < target && k < 200) begin wait_cycles(1); k++; end
    if (acc_cnt < target) check_eq("req_accept_timeout", acc_cnt, target);
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin wait_cycles(1); k++; end
    if (done_cnt < target) check_eq("done_timeout", done_cnt, target);
  endtask

  // stimulus
  initial begin
    int k, b0, d0, w0, r0;
    rst_n = 1'b0;
    wait_cycles(4);
    check_eq("rst_ctrl_addr", ctrl_addr, {OP_RD, PARK});
    check_eq("rst_wr_data", ctrl_wr_data, 0);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_wd_ready", wd_ready, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_sync_err", sync_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // interface reset phase, then parked slots only
    k = 0;
    while (park_cnt < 4 && k < INIT_LO + 200) begin wait_cycles(1); k++; end
    check_eq("park_slots", park_cnt >= 4, 1);
    check_eq("idle_req_ready", req_ready, 1);
    check_eq("idle_sync_err", sync_err, 0);

    // single write
    w0 = wdr_cnt; d0 = done_cnt;
    push_wd(16'h1234, 1);
    send_req(1'b1, 10'h200, 8'd0, 1'b0, 16'h1234);
    wait_done(d0 + 1, 100);
    wait_cycles(2);
    check_eq("wr1_wd_ready_cnt", wdr_cnt - w0, 1);

    // read burst of 4, incrementing
    r0 = rd_cnt; d0 = done_cnt;
    send_req(1'b0, 10'h010, 8'd3, 1'b0, 16'h0);
    wait_done(d0 + 1, 150);
    check_eq("rd4_count", rd_cnt - r0, 4);

    // fixed-address write burst with the first word withheld for one slot
    w0 = wdr_cnt; d0 = done_cnt;
    send_req(1'b1, 10'h22E, 8'd1, 1'b1, 16'hA0A0);
    b0 = m_bnd_cnt;
    k = 0;
    while (m_bnd_cnt == b0 && k < 20) begin wait_cycles(1); k++; end
    wait_cycles(1);
    check_eq("withhold_park", ctrl_addr, {OP_RD, PARK});
    push_wd(16'hA0A0, 2);
    wait_done(d0 + 1, 100);
    wait_cycles(2);
    check_eq("wr2_wd_ready_cnt", wdr_cnt - w0, 2);

    // address wrap 0x3FE -> 0x000
    r0 = rd_cnt; d0 = done_cnt;
    send_req(1'b0, 10'h3FE, 8'd1, 1'b0, 16'h0);
    wait_done(d0 + 1, 100);
    check_eq("wrap_rd_count", rd_cnt - r0, 2);

    // shortened access -> sticky sync_err, framing recovers
    check_eq("pre_short_sync_err", sync_err, 0);
    short_req_cnt++;
    wait_cycles(30);
    check_eq("short_sync_err", sync_err, 1);
    wait_cycles(21);
    check_eq("short_sync_err_sticky", sync_err, 1);
    r0 = rd_cnt; d0 = done_cnt;
    send_req(1'b0, 10'h100, 8'd0, 1'b0, 16'h0);
    wait_done(d0 + 1, 100);
    check_eq("post_short_rd_count", rd_cnt - r0, 1);

    wait_cycles(20);
    check_eq("stable_outputs", stab_err, 0);
    check_eq("acc_q_left", exp_acc_q.size(), 0);
    check_eq("rd_q_left", exp_rd_q.size(), 0);
    check_eq("done_q_left", exp_done_q.size(), 0);
    check_eq("wd_q_left", wd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
